z80_io_initiator: RTL
=====================

Z80_IO_INITIATOR -- requirements
Module: z80_io_initiator

Interface
REQ-001 Parameter AUTO_WAIT, default 1, sets automatic wait cycles after T2; legal range 1..3.
REQ-002 Parameter TIMEOUT, default 255, sets the maximum number of consecutive sampled wait_n-low cycles before abort; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_write  input  1  1 = OUT cycle, 0 = IN cycle.
REQ-008 req_addr  input  8  I/O port address.
REQ-009 req_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  8  read data; valid while rsp_valid is high.
REQ-012 rsp_err  output  1  timeout flag; valid while rsp_valid is high.
REQ-013 addr  output  8  bus address.
REQ-014 data_out  output  8  bus write data.
REQ-015 data_oe  output  1  data bus drive enable.
REQ-016 data_in  input  8  bus read data.
REQ-017 iorq_n, rd_n, wr_n  output  1 each  active-low bus strobes.
REQ-018 wait_n  input  1  active-low wait from the target, synchronous to clk.

Function
REQ-019 The FSM SHALL have the states IDLE, T1, T2, TW, T3, and all bus outputs SHALL be registered.
REQ-020 req_ready SHALL equal (state==IDLE), and a request SHALL be accepted on an edge where req_valid && req_ready.
REQ-021 On accept, the block SHALL latch addr, data_out and req_write, set data_oe=req_write, and enter T1 with all strobes high.
REQ-022 T1->T2 SHALL be unconditional, and in T2 iorq_n=0 and either rd_n=0 (read) or wr_n=0 (write).
REQ-023 T2->TW SHALL be unconditional and SHALL load the wait counter with AUTO_WAIT-1 and clear the timeout counter.
REQ-024 In TW, the block SHALL decrement the wait counter while it is nonzero and SHALL ignore wait_n during those cycles.
REQ-025 In TW, when the wait counter is 0 and wait_n=1, the block SHALL enter T3, and for reads it SHALL latch data_in into rsp_rdata on that edge.
REQ-026 In TW, when the wait counter is 0 and wait_n=0, the block SHALL stay in TW and increment the timeout counter.
REQ-027 When the timeout counter reaches TIMEOUT, the block SHALL enter T3 with the error flag set, and for reads rsp_rdata SHALL be 8'hFF.
REQ-028 Strobes and data_oe SHALL stay asserted through T2, TW and T3, and addr and data_out SHALL be stable from T1 through T3.
REQ-029 T3->IDLE SHALL be unconditional: strobes go high, data_oe goes 0, rsp_valid=1 for exactly one cycle, and rsp_err is set from the error flag.
REQ-030 With AUTO_WAIT=1 and wait_n high, rsp_valid SHALL rise on the 4th edge after the accept edge.
REQ-031 The earliest next accept SHALL be the edge after rsp_valid rises, giving a minimum spacing of 5 cycles between accepts.
REQ-032 req_* inputs SHALL be ignored outside IDLE, and no request SHALL be queued.
REQ-033 rd_n and wr_n SHALL never be low together, and iorq_n SHALL be low only in T2, TW and T3.
REQ-034 A timeout count of TIMEOUT=1 SHALL abort on the first sampled wait_n-low cycle.

Reset
REQ-035 Reset assertion SHALL immediately force state=IDLE, iorq_n=rd_n=wr_n=1, data_oe=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, addr=0, data_out=0, and both counters to 0, including mid-cycle.
REQ-036 After reset release, req_ready SHALL be 1 in the first cycle, and no completion pulse SHALL be issued for a cycle aborted by reset.

Verification
REQ-037 Read, wait_n=1, req_addr=8'h30, data_in=8'hA5 -> iorq_n/rd_n low for 3 cycles; rsp_valid pulse 4 edges after accept; rsp_rdata=8'hA5; rsp_err=0.
REQ-038 Write req_addr=8'h34, req_wdata=8'h01 -> wr_n low for 3 cycles; data_oe=1 from T1 through T3; data_out=8'h01; rd_n never low.
REQ-039 Read with wait_n held low for 5 cycles starting in TW -> strobes held for 8 cycles; data latched on the edge after wait_n rises; rsp_err=0.
REQ-040 TIMEOUT=4, wait_n stuck low -> T3 after 4 TW evaluation cycles; rsp_valid=1; rsp_err=1; rsp_rdata=8'hFF.
REQ-041 reset pulsed during TW -> strobes high and data_oe=0 immediately; no rsp_valid pulse; next request completes normally.
REQ-042 req_valid held high continuously with AUTO_WAIT=3 -> accepts spaced exactly 7 cycles apart; req_addr changes outside IDLE have no effect on addr.

Source files
------------

// File: rtl/z80_io_initiator.sv
// Z80-style I/O bus initiator: converts single req/rsp transactions into
// T1/T2/TW/T3 IN/OUT bus cycles with automatic wait states and wait_n timeout.
module z80_io_initiator #(
  parameter int AUTO_WAIT = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] addr,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  output logic       iorq_n,
  output logic       rd_n,
  output logic       wr_n,
  input  logic       wait_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3
  } state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(AUTO_WAIT - 1);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [1:0] wait_cnt, wait_cnt_nx;
  logic [7:0] tmo_cnt, tmo_cnt_nx;
  logic       is_write, is_write_nx;
  logic       err_flag, err_flag_nx;

  logic [7:0] addr_nx, data_out_nx, rsp_rdata_nx;
  logic       data_oe_nx, iorq_n_nx, rd_n_nx, wr_n_nx;
  logic       rsp_valid_nx, rsp_err_nx;

  assign req_ready = (state == S_IDLE);

  // Next-state logic also computes the next value of every bus output, so the
  // outputs themselves come straight from flops and never glitch.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    tmo_cnt_nx   = tmo_cnt;
    is_write_nx  = is_write;
    err_flag_nx  = err_flag;
    addr_nx      = addr;
    data_out_nx  = data_out;
    data_oe_nx   = data_oe;
    iorq_n_nx    = iorq_n;
    rd_n_nx      = rd_n;
    wr_n_nx      = wr_n;
    rsp_rdata_nx = rsp_rdata;
    rsp_valid_nx = 1'b0;
    rsp_err_nx   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nx    = S_T1;
          addr_nx     = req_addr;
          data_out_nx = req_wdata;
          is_write_nx = req_write;
          data_oe_nx  = req_write;
          err_flag_nx = 1'b0;
          iorq_n_nx   = 1'b1;
          rd_n_nx     = 1'b1;
          wr_n_nx     = 1'b1;
        end
      end

      S_T1: begin
        state_nx  = S_T2;
        iorq_n_nx = 1'b0;
        rd_n_nx   = is_write;
        wr_n_nx   = ~is_write;
      end

      S_T2: begin
        state_nx    = S_TW;
        wait_cnt_nx = WAIT_LOAD;
        tmo_cnt_nx  = '0;
      end

      S_TW: begin
        // Automatic wait states run first; wait_n only matters once they expire.
        if (wait_cnt != 2'd0) begin
          wait_cnt_nx = wait_cnt - 2'd1;
        end else if (wait_n) begin
          state_nx = S_T3;
          if (!is_write) rsp_rdata_nx = data_in;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx    = S_T3;
          tmo_cnt_nx  = tmo_cnt + 8'd1;
          err_flag_nx = 1'b1;
          if (!is_write) rsp_rdata_nx = 8'hFF;
        end else begin
          tmo_cnt_nx = tmo_cnt + 8'd1;
        end
      end

      S_T3: begin
        state_nx     = S_IDLE;
        iorq_n_nx    = 1'b1;
        rd_n_nx      = 1'b1;
        wr_n_nx      = 1'b1;
        data_oe_nx   = 1'b0;
        rsp_valid_nx = 1'b1;
        rsp_err_nx   = err_flag;
      end

      default: begin
        state_nx   = S_IDLE;
        iorq_n_nx  = 1'b1;
        rd_n_nx    = 1'b1;
        wr_n_nx    = 1'b1;
        data_oe_nx = 1'b0;
      end
    endcase
  end

  // Reset abandons any bus cycle in flight without a completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      tmo_cnt   <= '0;
      is_write  <= 1'b0;
      err_flag  <= 1'b0;
      addr      <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      iorq_n    <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      rsp_rdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      tmo_cnt   <= tmo_cnt_nx;
      is_write  <= is_write_nx;
      err_flag  <= err_flag_nx;
      addr      <= addr_nx;
      data_out  <= data_out_nx;
      data_oe   <= data_oe_nx;
      iorq_n    <= iorq_n_nx;
      rd_n      <= rd_n_nx;
      wr_n      <= wr_n_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_err   <= rsp_err_nx;
    end
  end

endmodule
